// File: rtl/tft_pkg.sv
// Shared definitions for the MCU pixel writer: geometry defaults,
// 8080 command codes and the write-path FSM state encoding.
package tft_pkg;

   localparam int COLS_DEF  = 800;
   localparam int ROWS_DEF  = 480;
   localparam int PAGES_DEF = 8;

   localparam logic [7:0] CMD_SET_PAGE  = 8'h10;
   localparam logic [7:0] CMD_SET_SHOW  = 8'h11;
   localparam logic [7:0] CMD_SET_COL   = 8'h2A;
   localparam logic [7:0] CMD_SET_ROW   = 8'h2B;
   localparam logic [7:0] CMD_WRITE_MEM = 8'h2C;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_ARG1,
      ST_ARG2,
      ST_PIX_HI,
      ST_PIX_LO
   } wr_state_e;

endpackage

// File: rtl/tft_mcu_pixel_writer_if.sv
// MCU byte bus plus pixel-FIFO write port. slave = pixel writer,
// master = the MCU / FIFO side that talks to it.
interface tft_mcu_pixel_writer_if;
   logic        bus_cs_n;
   logic        bus_wr_n;
   logic        bus_rs;
   logic [7:0]  bus_d;
   logic        bus_busy;
   logic        FIFO_wr_req;
   logic [15:0] FIFO_in;
   logic        FIFO_wr_full;

   modport slave (
      input  bus_cs_n, bus_wr_n, bus_rs, bus_d, FIFO_wr_full,
      output bus_busy, FIFO_wr_req, FIFO_in
   );

   modport master (
      output bus_cs_n, bus_wr_n, bus_rs, bus_d, FIFO_wr_full,
      input  bus_busy, FIFO_wr_req, FIFO_in
   );
endinterface

// File: rtl/tft_mcu_bus_sync.sv
// Brings the asynchronous 8080 pins into clk and flags each completed
// byte write (synchronised wr_n 0->1 while chip select is low).
// The strobe is combinational off the synchronisers, so the consumer
// acts on the third clk edge after the pin edge.
module tft_mcu_bus_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       rs,
   input  logic [7:0] d,
   output logic       byte_evt,
   output logic       rs_s,
   output logic [7:0] d_s
);

   logic [1:0] cs_ff;
   logic [1:0] wr_ff;
   logic [1:0] rs_ff;
   logic [7:0] d_ff0;
   logic [7:0] d_ff1;
   logic       wr_q;

   // two-flop synchronisers plus one history flop on wr_n for edge detect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_ff <= 2'b11;
         wr_ff <= 2'b11;
         rs_ff <= 2'b00;
         d_ff0 <= 8'h00;
         d_ff1 <= 8'h00;
         wr_q  <= 1'b1;
      end else begin
         cs_ff <= {cs_ff[0], cs_n};
         wr_ff <= {wr_ff[0], wr_n};
         rs_ff <= {rs_ff[0], rs};
         d_ff0 <= d;
         d_ff1 <= d_ff0;
         wr_q  <= wr_ff[1];
      end
   end

   assign byte_evt = wr_ff[1] & ~wr_q & ~cs_ff[1];
   assign rs_s     = rs_ff[1];
   assign d_s      = d_ff1;

endmodule

// File: rtl/tft_mcu_pixel_writer.sv
// Producer end of the frame-buffer write path: decodes MCU command/data
// bytes into RGB565 pixels for the pixel FIFO, owns the write address,
// display page and the power-up clear sweep.
module tft_mcu_pixel_writer
   import tft_pkg::*;
#(
   parameter int COLS  = COLS_DEF,
   parameter int ROWS  = ROWS_DEF,
   parameter int PAGES = PAGES_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   tft_mcu_pixel_writer_if.slave        bus,
   output logic                         startup,
   input  logic                         startup_inc,
   output logic [2:0]                   page_set,
   output logic [2:0]                   page_show,
   output logic [8:0]                   row_add_user,
   output logic [9:0]                   col_add_user,
   output logic                         overflow
);

   localparam logic [9:0] COL_MAX  = 10'(COLS - 1);
   localparam logic [8:0] ROW_MAX  = 9'(ROWS - 1);
   localparam logic [2:0] PAGE_MAX = 3'(PAGES - 1);

   wr_state_e   state, state_nxt;
   logic        evt, rs_s;
   logic [7:0]  d_s;
   logic        cmd_evt, dat_evt;
   logic [7:0]  cmd_q;
   logic [1:0]  arg_hi;
   logic [7:0]  pix_hi;
   logic        fifo_req_q;
   logic [15:0] fifo_in_q;
   logic        set_page_go, set_show_go, set_col_go, set_row_go, pix_go;
   logic        clear_last;
   logic [9:0]  col_val, col_clamp;
   logic [8:0]  row_val, row_clamp;

   tft_mcu_bus_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .cs_n     (bus.bus_cs_n),
      .wr_n     (bus.bus_wr_n),
      .rs       (bus.bus_rs),
      .d        (bus.bus_d),
      .byte_evt (evt),
      .rs_s     (rs_s),
      .d_s      (d_s)
   );

   // bytes arriving during the clear sweep are dropped here
   assign cmd_evt = evt & ~rs_s & (state != ST_CLEAR);
   assign dat_evt = evt &  rs_s & (state != ST_CLEAR);

   assign set_page_go = dat_evt & (state == ST_ARG1) & (cmd_q == CMD_SET_PAGE);
   assign set_show_go = dat_evt & (state == ST_ARG1) & (cmd_q == CMD_SET_SHOW);
   assign set_col_go  = dat_evt & (state == ST_ARG2) & (cmd_q == CMD_SET_COL);
   assign set_row_go  = dat_evt & (state == ST_ARG2) & (cmd_q == CMD_SET_ROW);
   assign pix_go      = dat_evt & (state == ST_PIX_LO);

   assign clear_last = (col_add_user == COL_MAX) & (row_add_user == ROW_MAX) &
                       (page_set == PAGE_MAX);

   assign col_val   = {arg_hi[1:0], d_s};
   assign col_clamp = (col_val > COL_MAX) ? COL_MAX : col_val;
   assign row_val   = {arg_hi[0], d_s};
   assign row_clamp = (row_val > ROW_MAX) ? ROW_MAX : row_val;

   assign startup         = (state != ST_CLEAR);
   assign bus.bus_busy    = (state == ST_CLEAR);
   assign bus.FIFO_wr_req = fifo_req_q;
   assign bus.FIFO_in     = fifo_in_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_CLEAR;
      else      state <= state_nxt;
   end

   // next state: a command byte always restarts decoding, discarding
   // any pending argument or half pixel
   always_comb begin
      state_nxt = state;
      if (state == ST_CLEAR) begin
         if (startup_inc && clear_last) state_nxt = ST_IDLE;
      end else if (cmd_evt) begin
         case (d_s)
            CMD_SET_PAGE, CMD_SET_SHOW,
            CMD_SET_COL,  CMD_SET_ROW:   state_nxt = ST_ARG1;
            CMD_WRITE_MEM:               state_nxt = ST_PIX_HI;
            default:                     state_nxt = ST_IDLE;
         endcase
      end else if (dat_evt) begin
         case (state)
            ST_ARG1:   state_nxt = ((cmd_q == CMD_SET_COL) || (cmd_q == CMD_SET_ROW)) ?
                                   ST_ARG2 : ST_IDLE;
            ST_ARG2:   state_nxt = ST_IDLE;
            ST_PIX_HI: state_nxt = ST_PIX_LO;
            ST_PIX_LO: state_nxt = ST_PIX_HI;
            default:   state_nxt = state;
         endcase
      end
   end

   // write address: clear sweep walks every page, afterwards commands
   // override the committed-pixel advance when both land together
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_add_user <= '0;
         row_add_user <= '0;
         page_set     <= '0;
      end else if (state == ST_CLEAR) begin
         if (startup_inc) begin
            if (col_add_user == COL_MAX) begin
               col_add_user <= '0;
               if (row_add_user == ROW_MAX) begin
                  row_add_user <= '0;
                  page_set     <= (page_set == PAGE_MAX) ? 3'd0 : page_set + 3'd1;
               end else begin
                  row_add_user <= row_add_user + 9'd1;
               end
            end else begin
               col_add_user <= col_add_user + 10'd1;
            end
         end
      end else if (set_page_go) begin
         page_set     <= d_s[2:0];
         row_add_user <= '0;
         col_add_user <= '0;
      end else if (set_col_go) begin
         col_add_user <= col_clamp;
      end else if (set_row_go) begin
         row_add_user <= row_clamp;
      end else if (startup_inc) begin
         if (col_add_user == COL_MAX) begin
            col_add_user <= '0;
            row_add_user <= (row_add_user == ROW_MAX) ? 9'd0 : row_add_user + 9'd1;
         end else begin
            col_add_user <= col_add_user + 10'd1;
         end
      end
   end

   // command/argument capture, display page, pixel assembly and FIFO push
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q      <= '0;
         arg_hi     <= '0;
         pix_hi     <= '0;
         page_show  <= '0;
         overflow   <= 1'b0;
         fifo_req_q <= 1'b0;
         fifo_in_q  <= '0;
      end else begin
         if (cmd_evt)                       cmd_q  <= d_s;
         if (dat_evt && state == ST_ARG1)   arg_hi <= d_s[1:0];
         if (dat_evt && state == ST_PIX_HI) pix_hi <= d_s;
         if (set_show_go)                   page_show <= d_s[2:0];
         fifo_req_q <= pix_go & ~bus.FIFO_wr_full;
         if (pix_go && !bus.FIFO_wr_full)   fifo_in_q <= {pix_hi, d_s};
         if (set_page_go)                        overflow <= 1'b0;
         else if (pix_go && bus.FIFO_wr_full)    overflow <= 1'b1;
      end
   end

endmodule
